ysyx_23060096_mem_arb: RTL and testbench
========================================

YSYX_23060096_MEM_ARB -- requirements
Module: ysyx_23060096_mem_arb

Interface
- REQ-001 The block SHALL have parameter TO_CYCLES, default 64: the number of WAIT cycles without mem_rvalid before a timeout.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-004 The block SHALL have these instruction-fetch ports:
  - if_req, input, 1 bit: fetch request.
  - if_addr, input, 32 bits: fetch address.
  - if_gnt, output, 1 bit: request accepted.
  - if_rvalid, output, 1 bit: response valid.
  - if_rdata, output, 32 bits: fetched word.
- REQ-005 The block SHALL have these load/store ports:
  - ls_req, input, 1 bit: load/store request.
  - ls_we, input, 1 bit: 1 = store.
  - ls_addr, input, 32 bits: address.
  - ls_wdata, input, 32 bits: store data.
  - ls_op, input, 3 bits: MemOP size/sign code.
  - ls_gnt, output, 1 bit: request accepted.
  - ls_rvalid, output, 1 bit: load data valid or store acknowledge.
  - ls_rdata, output, 32 bits: load data.
- REQ-006 The block SHALL have these memory-side ports:
  - mem_req, output, 1 bit.
  - mem_we, output, 1 bit.
  - mem_addr, output, 32 bits.
  - mem_wdata, output, 32 bits.
  - mem_op, output, 3 bits.
  - mem_ready, input, 1 bit: memory accepts the request.
  - mem_rvalid, input, 1 bit: response valid.
  - mem_rdata, input, 32 bits: response data.
- REQ-007 The block SHALL have port err_timeout, output, 1 bit: one-cycle pulse on a response timeout.

Function
- REQ-008 The block SHALL share one memory port between the IF and LS requesters using FSM states IDLE, REQ and WAIT.
- REQ-009 In IDLE, if any req is high, the block SHALL select an owner and latch that owner's addr/we/wdata/op (IF: we=0, op=3'b010 word), then move to REQ on the next edge.
- REQ-010 In REQ, the block SHALL drive mem_req=1 and the latched fields; on a cycle with mem_ready=1 it SHALL pulse the owner's gnt for exactly that cycle and move to WAIT.
- REQ-011 In WAIT, mem_req SHALL be 0; on mem_rvalid=1, the block SHALL drive the owner's rvalid=1 with rdata=mem_rdata for one cycle and return to IDLE.
- REQ-012 Minimum latency SHALL be: req seen in IDLE at cycle 0, mem_req at cycle 1, gnt at cycle 1 if mem_ready, rvalid in the same cycle as mem_rvalid; IDLE always costs one cycle between transactions.
- REQ-013 A requester SHALL hold req and its fields stable until gnt; the block ignores changes to the fields after latching.
- REQ-014 The non-owner's gnt and rvalid SHALL stay 0 throughout a transaction; its req stays pending.
- REQ-015 A 32-bit WAIT counter SHALL clear on entry to WAIT; when it reaches TO_CYCLES-1 without mem_rvalid, the block SHALL pulse err_timeout and the owner's rvalid with rdata=0, then go to IDLE.
- REQ-016 mem_rvalid received in IDLE or REQ SHALL be ignored (no rvalid, no state change).
- REQ-017 Any rdata output whose rvalid is 0 SHALL be 0.
- REQ-018 On a tie (both req high in IDLE) without the macro, LS SHALL win.

Reset
- REQ-019 rst=1 SHALL immediately force IDLE, counter=0, last_owner=IF, and all outputs 0, including mid-transaction; the abandoned transaction is not completed.

Configuration
- REQ-020 With YSYX_23060096_ARB_RR_EN defined, ties SHALL go to the requester not equal to last_owner (updated at each grant), so the first tie after reset goes to LS.
- REQ-021 Without YSYX_23060096_ARB_RR_EN, the fixed priority of REQ-018 SHALL apply and last_owner SHALL not exist.

Structure
- REQ-022 The FSM state enum, owner encoding (IF/LS) and the MemOP word constant SHALL live in package ysyx_23060096_pkg.
- REQ-023 The tie-break logic SHALL be sub-module ysyx_23060096_arb_pick (inputs: if_req, ls_req, last_owner; output: owner); everything else is in ysyx_23060096_mem_arb.

Verification
- REQ-024 Single fetch: if_req=1, if_addr=32'h8000_0000, mem_ready=1, mem_rvalid 2 cycles later with 32'h0000_0413 -> mem_addr=32'h8000_0000, if_gnt at cycle 1, if_rvalid=1 with if_rdata=32'h0000_0413.
- REQ-025 Store: ls_req=1, ls_we=1, ls_addr=32'h8000_1000, ls_wdata=32'hDEAD_BEEF, ls_op=3'b001 -> mem_we=1, mem_wdata=32'hDEAD_BEEF, mem_op=3'b001; ls_rvalid pulses on mem_rvalid.
- REQ-026 Tie: both req held for 4 transactions -> without the macro, LS,LS,LS,LS; with it, LS,IF,LS,IF.
- REQ-027 Backpressure: mem_ready=0 for 5 cycles in REQ -> mem_req and mem_addr stay stable, no gnt, grant on the 6th cycle.
- REQ-028 Timeout: TO_CYCLES=8, no mem_rvalid -> err_timeout and owner rvalid (rdata=0) pulse on the 8th WAIT cycle, then IDLE; a late mem_rvalid is ignored.
- REQ-029 rst pulse during WAIT -> all outputs 0 in the same cycle, FSM in IDLE, pending req re-arbitrated after rst falls.

Source files
------------

// File: rtl/ysyx_23060096_pkg.sv
// Shared types and constants for the IF/LS memory arbiter.
// Optional round-robin tie-break: define YSYX_23060096_ARB_RR_EN.
package ysyx_23060096_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_WAIT = 2'd2;

    // Requester that owns the memory port
    typedef logic owner_t;
    localparam owner_t OWNER_IF = 1'b0;
    localparam owner_t OWNER_LS = 1'b1;

    // MemOP code for a full 32-bit word
    localparam logic [2:0] MEMOP_W = 3'b010;

    // Request fields captured from the winning requester
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
    } mem_cmd_t;

endpackage

// File: rtl/ysyx_23060096_arb_pick.sv
// Chooses which requester owns the next memory transaction.
// Ties: LS wins, or alternate when YSYX_23060096_ARB_RR_EN is defined.
module ysyx_23060096_arb_pick
    import ysyx_23060096_pkg::*;
(
    input  logic if_req,
    input  logic ls_req,
    input  logic last_owner,
    output logic owner
);

`ifndef YSYX_23060096_ARB_RR_EN
    // Fixed priority never looks at the previous owner
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Resolve the winner; LS is the default when only LS or nobody asks
    always_comb begin
        owner = OWNER_LS;
        if (if_req && ls_req) begin
`ifdef YSYX_23060096_ARB_RR_EN
            owner = ~last_owner;
`else
            owner = OWNER_LS;
`endif
        end else if (if_req) begin
            owner = OWNER_IF;
        end
    end

endmodule

// File: rtl/ysyx_23060096_mem_arb.sv
// Shares one memory port between instruction fetch and load/store.
// Optional round-robin tie-break: define YSYX_23060096_ARB_RR_EN.
module ysyx_23060096_mem_arb
    import ysyx_23060096_pkg::*;
#(
    parameter int TO_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    input  logic [2:0]  ls_op,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_op,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        err_timeout
);

    localparam logic [31:0] TO_LAST = 32'(TO_CYCLES - 1);

    state_t      state;
    logic        owner;
    logic        pick;
    logic        last_owner;
    mem_cmd_t    cmd;
    logic [31:0] cnt;

    logic        in_req;
    logic        in_wait;
    logic        timeout;
    logic        done;
    logic        gnt_hit;
    logic [31:0] resp_data;

`ifdef YSYX_23060096_ARB_RR_EN
    logic last_q;
    assign last_owner = last_q;
`else
    assign last_owner = OWNER_IF;
`endif

    ysyx_23060096_arb_pick u_pick (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .last_owner (last_owner),
        .owner      (pick)
    );

    assign in_req    = (state == ST_REQ);
    assign in_wait   = (state == ST_WAIT);
    assign gnt_hit   = in_req && mem_ready;
    assign timeout   = in_wait && !mem_rvalid && (cnt == TO_LAST);
    assign done      = in_wait && (mem_rvalid || timeout);
    assign resp_data = mem_rvalid ? mem_rdata : 32'h0;

    // Latch the winner in IDLE, then walk REQ -> WAIT -> IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= OWNER_IF;
            cmd   <= '0;
            cnt   <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_req || ls_req) begin
                        owner <= pick;
                        state <= ST_REQ;
                        if (pick == OWNER_LS) begin
                            cmd <= '{we: ls_we, addr: ls_addr,
                                     wdata: ls_wdata, op: ls_op};
                        end else begin
                            cmd <= '{we: 1'b0, addr: if_addr,
                                     wdata: 32'h0, op: MEMOP_W};
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        state <= ST_WAIT;
                        cnt   <= 32'h0;
                    end
                end
                ST_WAIT: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 32'h1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef YSYX_23060096_ARB_RR_EN
    // Remember who was granted last for alternating tie-breaks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= OWNER_IF;
        end else if (gnt_hit) begin
            last_q <= owner;
        end
    end
`endif

    // Memory-side command is only visible while requesting
    always_comb begin
        mem_req   = in_req;
        mem_we    = in_req && cmd.we;
        mem_addr  = in_req ? cmd.addr : 32'h0;
        mem_wdata = in_req ? cmd.wdata : 32'h0;
        mem_op    = in_req ? cmd.op : 3'b000;
    end

    // Route grant and response to the owner only
    always_comb begin
        if_gnt      = gnt_hit && (owner == OWNER_IF);
        ls_gnt      = gnt_hit && (owner == OWNER_LS);
        if_rvalid   = done && (owner == OWNER_IF);
        ls_rvalid   = done && (owner == OWNER_LS);
        if_rdata    = if_rvalid ? resp_data : 32'h0;
        ls_rdata    = ls_rvalid ? resp_data : 32'h0;
        err_timeout = timeout;
    end

endmodule

// File: tb/tb_ysyx_23060096_mem_arb.sv
// Directed scoreboard bench for the IF/LS memory arbiter.
// Tie expectations follow YSYX_23060096_ARB_RR_EN when defined.
module tb_ysyx_23060096_mem_arb;
    import ysyx_23060096_pkg::*;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [2:0]  ls_op;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_op;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
    } req_t;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    logic model_last;

    ysyx_23060096_mem_arb #(.TO_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .ls_req      (ls_req),
        .ls_we       (ls_we),
        .ls_addr     (ls_addr),
        .ls_wdata    (ls_wdata),
        .ls_op       (ls_op),
        .ls_gnt      (ls_gnt),
        .ls_rvalid   (ls_rvalid),
        .ls_rdata    (ls_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_op      (mem_op),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, err_timeout}),
            32'h0);
        chk(tag, if_rdata | ls_rdata, 32'h0);
    endtask

    task automatic chk_cmd(input string tag, input req_t e);
        chk(tag, 32'(mem_req), 32'h1);
        chk(tag, 32'(mem_we), 32'(e.we));
        chk(tag, mem_addr, e.addr);
        chk(tag, mem_wdata, e.wdata);
        chk(tag, 32'(mem_op), 32'(e.op));
    endtask

    function automatic logic model_pick();
        if (if_req && ls_req) begin
`ifdef YSYX_23060096_ARB_RR_EN
            return ~model_last;
`else
            return OWNER_LS;
`endif
        end
        return if_req ? OWNER_IF : OWNER_LS;
    endfunction

    // One full transaction starting in IDLE; fixed cycle counts only
    task automatic txn(input int rdy_dly, input int lat,
                       input logic [31:0] d, input bit to,
                       input bit keep, input bit rv_early);
        req_t e;
        rsp_t r;
        logic o;
        #1;
        chk("idle_mreq", 32'(mem_req), 32'h0);
        chk_quiet("idle_quiet");
        o = model_pick();
        if (o == OWNER_LS)
            e = '{owner: o, we: ls_we, addr: ls_addr,
                  wdata: ls_wdata, op: ls_op};
        else
            e = '{owner: o, we: 1'b0, addr: if_addr,
                  wdata: 32'h0, op: MEMOP_W};
        req_q.push_back(e);
        step();
        for (int i = 0; i < rdy_dly; i++) begin
            mem_ready  = 1'b0;
            mem_rvalid = rv_early;
            mem_rdata  = 32'hBAD0_0000 | 32'(i);
            #1;
            chk_cmd("bp_cmd", req_q[0]);
            chk_quiet("bp_quiet");
            step();
        end
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        mem_ready  = 1'b1;
        #1;
        e = req_q.pop_front();
        chk_cmd("gnt_cmd", e);
        chk("gnt", 32'({if_gnt, ls_gnt}), e.owner ? 32'h1 : 32'h2);
        chk("gnt_rv", 32'({if_rvalid, ls_rvalid}), 32'h0);
        model_last = e.owner;
        step();
        mem_ready = 1'b0;
        if (!keep) begin
            if (e.owner == OWNER_LS) ls_req = 1'b0;
            else if_req = 1'b0;
        end
        for (int i = 0; i < (to ? TO - 1 : lat); i++) begin
            #1;
            chk("wait_mreq", 32'(mem_req), 32'h0);
            chk_quiet("wait_quiet");
            step();
        end
        if (to) begin
            rsp_q.push_back('{owner: e.owner, data: 32'h0});
            #1;
            r = rsp_q.pop_front();
            chk("timeout", 32'(err_timeout), 32'h1);
        end else begin
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            rsp_q.push_back('{owner: e.owner, data: d});
            #1;
            r = rsp_q.pop_front();
            chk("no_timeout", 32'(err_timeout), 32'h0);
        end
        chk("rvalid", 32'({if_rvalid, ls_rvalid}), r.owner ? 32'h1 : 32'h2);
        chk("rdata", r.owner ? ls_rdata : if_rdata, r.data);
        chk("other_rdata", r.owner ? if_rdata : ls_rdata, 32'h0);
        chk("resp_mreq", 32'(mem_req), 32'h0);
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, 32'({mem_req, mem_we, mem_op}), 32'h0);
        chk(tag, mem_addr | mem_wdata, 32'h0);
        chk_quiet(tag);
    endtask

    initial begin
        rst        = 1'b1;
        if_req     = 1'b0;
        if_addr    = 32'h0;
        ls_req     = 1'b0;
        ls_we      = 1'b0;
        ls_addr    = 32'h0;
        ls_wdata   = 32'h0;
        ls_op      = 3'b000;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        model_last = OWNER_IF;
        #3;
        chk_all_zero("reset");
        step();
        step();
        rst = 1'b0;

        // Single fetch
        if_req  = 1'b1;
        if_addr = 32'h8000_0000;
        txn(0, 1, 32'h0000_0413, 1'b0, 1'b0, 1'b0);

        // Store
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h8000_1000;
        ls_wdata = 32'hDEAD_BEEF;
        ls_op    = 3'b001;
        txn(0, 2, 32'h0, 1'b0, 1'b0, 1'b0);

        // Load answered on the first WAIT cycle
        ls_req   = 1'b1;
        ls_we    = 1'b0;
        ls_addr  = 32'h8000_2004;
        ls_wdata = 32'h0;
        ls_op    = 3'b100;
        txn(0, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

        // Backpressure with stray mem_rvalid during REQ
        if_req  = 1'b1;
        if_addr = 32'h8000_0010;
        txn(5, 1, 32'hCAFE_0001, 1'b0, 1'b0, 1'b1);

        // Ties held for four transactions
        if_req   = 1'b1;
        if_addr  = 32'h8000_0100;
        ls_req   = 1'b1;
        ls_we    = 1'b0;
        ls_addr  = 32'h8000_3000;
        ls_op    = 3'b010;
        for (int k = 0; k < 4; k++) begin
            txn(0, 1, 32'h5000_0000 + 32'(k), 1'b0, 1'b1, 1'b0);
        end
        if_req = 1'b0;
        ls_req = 1'b0;

        // Timeout, then a late response in IDLE is ignored
        ls_req  = 1'b1;
        ls_addr = 32'h8000_4000;
        txn(0, 0, 32'h0, 1'b1, 1'b0, 1'b0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_0000;
        #1;
        chk("late_mreq", 32'(mem_req), 32'h0);
        chk_quiet("late_quiet");
        step();
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // Reset in WAIT abandons the transaction
        if_req  = 1'b1;
        if_addr = 32'h8000_0020;
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #1;
        chk("pre_rst_mreq", 32'(mem_req), 32'h0);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        #1;
        chk_all_zero("rst_mid");
        step();
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        model_last = OWNER_IF;
        txn(0, 1, 32'h0000_0093, 1'b0, 1'b0, 1'b0);

        chk("req_q_empty", 32'(req_q.size()), 32'h0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
